// File: rtl/mem_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_sequencer                                                |
// | Description : Multi-byte big-endian load/store sequencer for a byte-wide   |
// |               memory with a pipelined read path.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_sequencer #(
    parameter int ADDR_WIDTH   = 9,
    parameter int MAX_BYTES    = 4,
    parameter int READ_LATENCY = 2,
    parameter int ALIGN_CHECK  = 0,
    localparam int DATA_WIDTH  = 8 * MAX_BYTES,
    localparam int SIZE_WIDTH  = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  we,
    input  logic [SIZE_WIDTH-1:0] size,
    input  logic                  sext,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [7:0]            mem_data_out,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [7:0]            mem_data_in,
    output logic                  mem_write
);

    localparam int c_NW = $clog2(MAX_BYTES + 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_STORE = 2'd2;
    localparam logic [1:0] c_ERROR = 2'd3;

    logic [1:0]              r_state;
    logic [1:0]              w_state_next;
    logic [c_NW-1:0]         r_n;
    logic                    r_sext;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wsh;
    logic [c_NW-1:0]         r_icnt;
    logic [c_NW-1:0]         r_rcnt;
    logic [READ_LATENCY-1:0] r_vld;
    logic [DATA_WIDTH-1:0]   r_asm;

    logic [c_NW:0]           w_n_raw;
    logic [c_NW-1:0]         w_n;
    logic                    w_misaligned;
    logic                    w_issue;
    logic                    w_sample;
    logic                    w_last_rd;
    logic                    w_last_wr;
    logic                    w_sign;
    logic [DATA_WIDTH-1:0]   w_asm_next;
    logic [DATA_WIDTH-1:0]   w_rdata_next;

    // Requested byte count, clamped to the widest supported access
    always_comb begin
        w_n_raw = (c_NW+1)'(size) + (c_NW+1)'(1);
        if (w_n_raw > (c_NW+1)'(MAX_BYTES)) begin
            w_n = c_NW'(MAX_BYTES);
        end else begin
            w_n = w_n_raw[c_NW-1:0];
        end
    end

    generate
        if (ALIGN_CHECK != 0) begin : g_align_on
            assign w_misaligned = (w_n > c_NW'(1)) &&
                                  ((addr % ADDR_WIDTH'(w_n)) != '0);
        end else begin : g_align_off
            assign w_misaligned = 1'b0;
        end
    endgenerate

    assign busy      = (r_state != c_IDLE);
    assign w_issue   = (r_state == c_LOAD) && (r_icnt != r_n);
    assign w_sample  = r_vld[READ_LATENCY-1];
    assign w_last_rd = w_sample && (r_rcnt == r_n - c_NW'(1));
    assign w_last_wr = (r_state == c_STORE) && (r_icnt == r_n - c_NW'(1));

    // Big-endian assembly: each new byte enters at the bottom
    always_comb begin
        w_asm_next = (r_asm << 8) | DATA_WIDTH'(mem_data_out);
        w_sign     = 1'b0;
        for (int b = 1; b <= MAX_BYTES; b++) begin
            if (r_n == c_NW'(b)) begin
                w_sign = r_sext & w_asm_next[8*b-1];
            end
        end
        w_rdata_next = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_rdata_next[i] = (i < 8 * int'(r_n)) ? w_asm_next[i] : w_sign;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    if (w_misaligned) begin
                        w_state_next = c_ERROR;
                    end else if (we) begin
                        w_state_next = c_STORE;
                    end else begin
                        w_state_next = c_LOAD;
                    end
                end
            end
            c_LOAD: begin
                if (w_last_rd) begin
                    w_state_next = c_IDLE;
                end
            end
            c_STORE: begin
                if (w_last_wr) begin
                    w_state_next = c_IDLE;
                end
            end
            c_ERROR: w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_n         <= '0;
            r_sext      <= 1'b0;
            r_addr      <= '0;
            r_wsh       <= '0;
            r_icnt      <= '0;
            r_rcnt      <= '0;
            r_vld       <= '0;
            r_asm       <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            rdata       <= '0;
            mem_raddr   <= '0;
            mem_waddr   <= '0;
            mem_data_in <= '0;
            mem_write   <= 1'b0;
        end else begin
            done      <= 1'b0;
            err       <= 1'b0;
            mem_write <= 1'b0;
            r_vld     <= (r_vld << 1) | READ_LATENCY'(w_issue);
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_n    <= w_n;
                        r_sext <= sext;
                        r_addr <= addr;
                        // Pre-align so the most significant used byte sits on top
                        r_wsh  <= wdata << (8 * (MAX_BYTES - int'(w_n)));
                        r_icnt <= '0;
                        r_rcnt <= '0;
                        r_asm  <= '0;
                    end
                end
                c_LOAD: begin
                    if (w_issue) begin
                        mem_raddr <= r_addr + ADDR_WIDTH'(r_icnt);
                        r_icnt    <= r_icnt + c_NW'(1);
                    end
                    if (w_sample) begin
                        r_asm  <= w_asm_next;
                        r_rcnt <= r_rcnt + c_NW'(1);
                    end
                    if (w_last_rd) begin
                        rdata <= w_rdata_next;
                        done  <= 1'b1;
                    end
                end
                c_STORE: begin
                    mem_write   <= 1'b1;
                    mem_waddr   <= r_addr + ADDR_WIDTH'(r_icnt);
                    mem_data_in <= r_wsh[DATA_WIDTH-1 -: 8];
                    r_wsh       <= r_wsh << 8;
                    r_icnt      <= r_icnt + c_NW'(1);
                    if (w_last_wr) begin
                        done <= 1'b1;
                    end
                end
                c_ERROR: begin
                    done <= 1'b1;
                    err  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_sequencer                                             |
// | Description : Scoreboard bench for mem_sequencer (default and wide builds) |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    logic init_mem;

    // Build A: defaults (4 bytes, latency 2, no alignment check)
    logic        rst_a_n, start_a, we_a, sext_a;
    logic [1:0]  size_a;
    logic [8:0]  addr_a, mem_raddr_a, mem_waddr_a;
    logic [31:0] wdata_a, rdata_a;
    logic        busy_a, done_a, err_a, mem_write_a;
    logic [7:0]  rd_a_q, mem_data_in_a;
    logic [7:0]  mem_a [512];

    // Build B: 8 bytes, latency 3, alignment check on
    logic        rst_b_n, start_b, we_b, sext_b;
    logic [2:0]  size_b;
    logic [8:0]  addr_b, mem_raddr_b, mem_waddr_b;
    logic [63:0] wdata_b, rdata_b;
    logic        busy_b, done_b, err_b, mem_write_b;
    logic [7:0]  rd_b_q1, rd_b_q2, mem_data_in_b;
    logic [7:0]  mem_b [512];

    mem_sequencer dut_a (
        .clk(clk), .reset_n(rst_a_n), .start(start_a), .we(we_a), .size(size_a),
        .sext(sext_a), .addr(addr_a), .wdata(wdata_a), .busy(busy_a), .done(done_a),
        .err(err_a), .rdata(rdata_a), .mem_raddr(mem_raddr_a), .mem_data_out(rd_a_q),
        .mem_waddr(mem_waddr_a), .mem_data_in(mem_data_in_a), .mem_write(mem_write_a)
    );

    mem_sequencer #(.ADDR_WIDTH(9), .MAX_BYTES(8), .READ_LATENCY(3), .ALIGN_CHECK(1)) dut_b (
        .clk(clk), .reset_n(rst_b_n), .start(start_b), .we(we_b), .size(size_b),
        .sext(sext_b), .addr(addr_b), .wdata(wdata_b), .busy(busy_b), .done(done_b),
        .err(err_b), .rdata(rdata_b), .mem_raddr(mem_raddr_b), .mem_data_out(rd_b_q2),
        .mem_waddr(mem_waddr_b), .mem_data_in(mem_data_in_b), .mem_write(mem_write_b)
    );

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 512; i++) mem_a[i] <= 8'h00;
            mem_a[16] <= 8'hDE; mem_a[17] <= 8'hAD; mem_a[18] <= 8'hBE; mem_a[19] <= 8'hEF;
        end else if (mem_write_a) begin
            mem_a[mem_waddr_a] <= mem_data_in_a;
        end
        rd_a_q <= mem_a[mem_raddr_a];
    end

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 512; i++) mem_b[i] <= 8'h00;
            mem_b[16] <= 8'hDE; mem_b[17] <= 8'hAD; mem_b[18] <= 8'hBE; mem_b[19] <= 8'hEF;
            mem_b[20] <= 8'h01; mem_b[21] <= 8'h23; mem_b[22] <= 8'h45; mem_b[23] <= 8'h67;
            mem_b[2]  <= 8'hC3; mem_b[3]  <= 8'h5A;
        end else if (mem_write_b) begin
            mem_b[mem_waddr_b] <= mem_data_in_b;
        end
        rd_b_q1 <= mem_b[mem_raddr_b];
        rd_b_q2 <= rd_b_q1;
    end

    typedef struct { logic err; logic [63:0] rdata; int cyc; } done_t;
    typedef struct { int cyc; logic [8:0] adr; logic [7:0] dat; } acc_t;
    done_t qa[$], qb[$];
    acc_t  wqa[$], wqb[$], rqa[$], rqb[$];
    done_t mon_d;
    acc_t  mon_x;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUTs present a response
    always @(negedge clk) begin
        if (done_a) begin
            if (qa.size() == 0) chk("A unexpected done", {63'd0, done_a}, 64'd0);
            else begin
                mon_d = qa.pop_front();
                chk("A done cycle", 64'(cyc), 64'(mon_d.cyc));
                chk("A err", {63'd0, err_a}, {63'd0, mon_d.err});
                chk("A rdata", {32'd0, rdata_a}, mon_d.rdata);
            end
        end
        if (done_b) begin
            if (qb.size() == 0) chk("B unexpected done", {63'd0, done_b}, 64'd0);
            else begin
                mon_d = qb.pop_front();
                chk("B done cycle", 64'(cyc), 64'(mon_d.cyc));
                chk("B err", {63'd0, err_b}, {63'd0, mon_d.err});
                chk("B rdata", rdata_b, mon_d.rdata);
            end
        end
        if (mem_write_a) begin
            if (wqa.size() == 0) chk("A unexpected write", {63'd0, mem_write_a}, 64'd0);
            else begin
                mon_x = wqa.pop_front();
                chk("A write cycle", 64'(cyc), 64'(mon_x.cyc));
                chk("A waddr", 64'(mem_waddr_a), 64'(mon_x.adr));
                chk("A wdata", 64'(mem_data_in_a), 64'(mon_x.dat));
            end
        end
        if (mem_write_b) begin
            if (wqb.size() == 0) chk("B unexpected write", {63'd0, mem_write_b}, 64'd0);
            else begin
                mon_x = wqb.pop_front();
                chk("B write cycle", 64'(cyc), 64'(mon_x.cyc));
                chk("B waddr", 64'(mem_waddr_b), 64'(mon_x.adr));
                chk("B wdata", 64'(mem_data_in_b), 64'(mon_x.dat));
            end
        end
        if (rqa.size() != 0 && rqa[0].cyc == cyc) begin
            mon_x = rqa.pop_front();
            chk("A raddr", 64'(mem_raddr_a), 64'(mon_x.adr));
        end
        if (rqb.size() != 0 && rqb[0].cyc == cyc) begin
            mon_x = rqb.pop_front();
            chk("B raddr", 64'(mem_raddr_b), 64'(mon_x.adr));
        end
    end

    task automatic issue_a(input logic w, input int n, input logic sx, input logic [8:0] ad,
                           input logic [31:0] wd, output int s);
        we_a = w; size_a = 2'(n - 1); sext_a = sx; addr_a = ad; wdata_a = wd; start_a = 1'b1;
        s = cyc + 1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic issue_b(input logic w, input int n, input logic sx, input logic [8:0] ad,
                           input logic [63:0] wd, output int s);
        we_b = w; size_b = 3'(n - 1); sext_b = sx; addr_b = ad; wdata_b = wd; start_b = 1'b1;
        s = cyc + 1;
        @(negedge clk);
        start_b = 1'b0;
    endtask

    task automatic exp_done(input logic b, input logic e, input logic [63:0] rd, input int c);
        done_t d;
        d.err = e; d.rdata = rd; d.cyc = c;
        if (b) qb.push_back(d); else qa.push_back(d);
    endtask

    task automatic exp_load(input logic b, input int s, input int n, input int lat,
                            input logic [8:0] ad, input logic [63:0] rd);
        acc_t x;
        for (int k = 0; k < n; k++) begin
            x.cyc = s + 1 + k; x.adr = ad + 9'(k); x.dat = 8'h00;
            if (b) rqb.push_back(x); else rqa.push_back(x);
        end
        exp_done(b, 1'b0, rd, s + n + lat);
    endtask

    task automatic exp_writes_a(input int s, input int n, input int nw, input logic [8:0] ad,
                                input logic [31:0] wd);
        acc_t x;
        for (int k = 0; k < nw; k++) begin
            x.cyc = s + 1 + k; x.adr = ad + 9'(k); x.dat = 8'(wd >> (8 * (n - 1 - k)));
            wqa.push_back(x);
        end
    endtask

    task automatic drain(input int lim);
        int i;
        i = 0;
        while ((qa.size() + qb.size() + wqa.size() + wqb.size() + rqa.size() + rqb.size()) != 0
               && i < lim) begin
            @(negedge clk); #1;
            i++;
        end
        chk("drain pending", 64'(qa.size() + qb.size() + wqa.size() + wqb.size()
                                 + rqa.size() + rqb.size()), 64'd0);
    endtask

    initial begin
        int s;
        rst_a_n = 1'b0; rst_b_n = 1'b0; init_mem = 1'b1;
        start_a = 1'b0; we_a = 1'b0; sext_a = 1'b0; size_a = '0; addr_a = '0; wdata_a = '0;
        start_b = 1'b0; we_b = 1'b0; sext_b = 1'b0; size_b = '0; addr_b = '0; wdata_b = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", {63'd0, busy_a}, 64'd0);
        chk("reset done", {63'd0, done_a}, 64'd0);
        chk("reset err", {63'd0, err_a}, 64'd0);
        chk("reset rdata", {32'd0, rdata_a}, 64'd0);
        chk("reset raddr", 64'(mem_raddr_a), 64'd0);
        chk("reset waddr", 64'(mem_waddr_a), 64'd0);
        chk("reset wdata", 64'(mem_data_in_a), 64'd0);
        chk("reset mem_write", {63'd0, mem_write_a}, 64'd0);
        chk("B reset rdata", rdata_b, 64'd0);
        chk("B reset busy", {63'd0, busy_b}, 64'd0);
        init_mem = 1'b0; rst_a_n = 1'b1; rst_b_n = 1'b1;
        @(negedge clk); #1;

        // Loads on build A
        issue_a(1'b0, 4, 1'b0, 9'h010, 32'h0, s); exp_load(1'b0, s, 4, 2, 9'h010, 64'hDEADBEEF);
        drain(40);
        issue_a(1'b0, 1, 1'b1, 9'h012, 32'h0, s); exp_load(1'b0, s, 1, 2, 9'h012, 64'hFFFFFFBE);
        drain(40);
        issue_a(1'b0, 1, 1'b0, 9'h012, 32'h0, s); exp_load(1'b0, s, 1, 2, 9'h012, 64'h000000BE);
        drain(40);
        issue_a(1'b0, 2, 1'b1, 9'h010, 32'h0, s); exp_load(1'b0, s, 2, 2, 9'h010, 64'hFFFFDEAD);
        drain(40);

        // Wrapping store, load issued in its done cycle, stray starts while busy
        issue_a(1'b1, 4, 1'b0, 9'h1FE, 32'h11223344, s);
        exp_writes_a(s, 4, 4, 9'h1FE, 32'h11223344);
        exp_done(1'b0, 1'b0, 64'hFFFFDEAD, s + 4);
        repeat (4) @(negedge clk);
        chk("A busy in done cycle", {63'd0, busy_a}, 64'd0);
        issue_a(1'b0, 4, 1'b0, 9'h1FE, 32'h0, s); exp_load(1'b0, s, 4, 2, 9'h1FE, 64'h11223344);
        we_a = 1'b1; addr_a = 9'h100; start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        drain(40);

        // Reset in the middle of a store after two writes
        issue_a(1'b1, 4, 1'b0, 9'h040, 32'hAABBCCDD, s);
        exp_writes_a(s, 4, 2, 9'h040, 32'hAABBCCDD);
        @(negedge clk); @(negedge clk);
        #1 rst_a_n = 1'b0;
        #1;
        chk("A reset mem_write", {63'd0, mem_write_a}, 64'd0);
        chk("A reset busy", {63'd0, busy_a}, 64'd0);
        chk("A reset done", {63'd0, done_a}, 64'd0);
        chk("A reset rdata", {32'd0, rdata_a}, 64'd0);
        @(negedge clk); @(negedge clk);
        rst_a_n = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        issue_a(1'b0, 2, 1'b0, 9'h040, 32'h0, s); exp_load(1'b0, s, 2, 2, 9'h040, 64'h0000AA00);
        drain(40);

        // Build B: 8-byte load, alignment errors, aligned 2-byte load
        issue_b(1'b0, 8, 1'b0, 9'h010, 64'h0, s);
        exp_load(1'b1, s, 8, 3, 9'h010, 64'hDEADBEEF01234567);
        drain(40);
        issue_b(1'b0, 4, 1'b0, 9'h002, 64'h0, s);
        exp_done(1'b1, 1'b1, 64'hDEADBEEF01234567, s + 1);
        drain(40);
        issue_b(1'b1, 4, 1'b0, 9'h006, 64'h0102030405060708, s);
        exp_done(1'b1, 1'b1, 64'hDEADBEEF01234567, s + 1);
        drain(40);
        issue_b(1'b0, 2, 1'b1, 9'h002, 64'h0, s);
        exp_load(1'b1, s, 2, 3, 9'h002, 64'hFFFFFFFFFFFFC35A);
        drain(40);

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
